// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the CPU data bus.
//
// Register map (byte addresses):
//   BASE_ADDR + 0 : TXDATA  (write pushes data_in[7:0] into the TX FIFO, reads 0)
//   BASE_ADDR + 4 : STATUS  (read {count[3:0], ovf, tx_busy, empty, full};
//                            writing 1 to bit 3 clears ovf)
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   mem_addr        CPU data address; [31:3] decoded, [2] selects the word
//   memwr, memrd    CPU write / read strobes (reads do not depend on memrd)
//   data_in         CPU write data
//   data_out        combinational read data (0 unless STATUS is addressed)
//   sel             combinational address hit, used by the top to mux with RAM
//   tx              registered serial output, idle high
//   tx_busy         registered, high while a frame is in flight

module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int unsigned CLK_DIV    = 434,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic        memwr,
    input  logic        memrd,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        sel,
    output logic        tx,
    output logic        tx_busy
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BCNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic wr_txdata;
    logic wr_status;

    assign sel       = (mem_addr[31:3] == BASE_ADDR[31:3]);
    assign wr_txdata = sel & memwr & ~mem_addr[2];
    assign wr_status = sel & memwr &  mem_addr[2];

    // Bus bits this block deliberately ignores.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{memrd, mem_addr[1:0], data_in[31:8]};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [7:0]        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;

    state_e            state_q, state_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [2:0]        bidx_q, bidx_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic bcnt_done;

    // Fullness is taken from the registered count, so a push into a full FIFO
    // is dropped even when the FSM pops in the same cycle.
    assign fifo_full  = (count_q == DEPTH_CNT);
    assign fifo_empty = (count_q == '0);
    assign push       = wr_txdata & ~fifo_full;
    assign bcnt_done  = (bcnt_q == BCNT_LAST);

    // ------------------------------------------------------------------
    // FIFO and overflow flag next-state
    // ------------------------------------------------------------------
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (push) begin
            mem_d[wptr_q] = data_in[7:0];
            wptr_d        = wptr_q + PTR_W'(1);
        end

        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (wr_txdata && fifo_full) begin
            ovf_d = 1'b1;
        end else if (wr_status && data_in[3]) begin
            ovf_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // TX FSM next-state and registered line outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q + BCNT_W'(1);
        bidx_d  = bidx_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                bcnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rptr_q];
                    state_d = S_START;
                end
            end

            S_START: begin
                if (bcnt_done) begin
                    bcnt_d  = '0;
                    bidx_d  = 3'd0;
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (bcnt_done) begin
                    bcnt_d = '0;
                    if (bidx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bidx_d = bidx_q + 3'd1;
                    end
                end
            end

            S_STOP: begin
                if (bcnt_done) begin
                    bcnt_d = '0;
                    // Chain straight into the next start bit when data waits.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = mem_q[rptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                bcnt_d  = '0;
                state_d = S_IDLE;
            end
        endcase

        // Line level follows the state being entered so tx lines up with it.
        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shreg_d[bidx_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            state_q <= S_IDLE;
            bcnt_q  <= '0;
            bidx_q  <= 3'd0;
            shreg_q <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            bidx_q  <= bidx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;

    // ------------------------------------------------------------------
    // Read data
    // ------------------------------------------------------------------
    logic [4:0]  count_ext;
    logic [31:0] status_word;

    // A 16-deep full FIFO wraps to 0 in the 4-bit field; full flags it.
    assign count_ext   = 5'(count_q);
    assign status_word = {24'b0, count_ext[3:0], ovf_q, busy_q, fifo_empty, fifo_full};
    assign data_out    = (sel && mem_addr[2]) ? status_word : 32'h0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx (CLK_DIV=4, FIFO_DEPTH=8).

module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam int unsigned DIV  = 4;

    logic        clk;
    logic        reset;
    logic [31:0] mem_addr;
    logic        memwr;
    logic        memrd;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        sel;
    logic        tx;
    logic        tx_busy;

    int n_checks = 0;
    int n_errors = 0;

    mmio_uart_tx #(
        .BASE_ADDR (BASE),
        .CLK_DIV   (DIV),
        .FIFO_DEPTH(8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .mem_addr(mem_addr),
        .memwr   (memwr),
        .memrd   (memrd),
        .data_in (data_in),
        .data_out(data_out),
        .sel     (sel),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        mem_addr = addr;
        data_in  = data;
        memwr    = 1'b1;
        tick();
        memwr    = 1'b0;
    endtask

    task automatic read_word(input logic [31:0] addr, input logic rd, output logic [31:0] val);
        mem_addr = addr;
        memrd    = rd;
        #1;
        val      = data_out;
        memrd    = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic [31:0] exp);
        logic [31:0] v;
        read_word(BASE + 32'd4, 1'b1, v);
        check(tag, 64'(v), 64'(exp));
    endtask

    // Samples tx for one full frame starting on its first start-bit cycle.
    task automatic check_frame(input string tag, input logic [7:0] b);
        logic [9:0]  fr;
        logic [39:0] obs;
        logic [39:0] exp;
        fr = {1'b1, b, 1'b0};
        for (int k = 0; k < 10 * int'(DIV); k++) begin
            exp[k] = fr[k / int'(DIV)];
            obs[k] = tx;
            tick();
        end
        check(tag, 64'(obs), 64'(exp));
    endtask

    initial begin
        logic [31:0] v;
        int          bad;

        reset    = 1'b1;
        mem_addr = 32'h0;
        memwr    = 1'b0;
        memrd    = 1'b0;
        data_in  = 32'h0;

        // 1: reset and idle
        repeat (3) tick();
        reset = 1'b0;
        repeat (20) tick();
        check("idle_tx", 64'(tx), 64'd1);
        check("idle_busy", 64'(tx_busy), 64'd0);
        check_status("idle_status", 32'h0000_0002);

        // 2: single frame, upper data bits ignored
        bus_write(BASE, 32'h0000_0155);
        check("wr_tx_still_high", 64'(tx), 64'd1);
        check_status("wr_count1", 32'h0000_0010);
        tick();
        check("start_tx_low", 64'(tx), 64'd0);
        check("start_busy", 64'(tx_busy), 64'd1);
        check_status("popped_status", 32'h0000_0006);
        check_frame("frame_55", 8'h55);
        check("after_frame_busy", 64'(tx_busy), 64'd0);
        check("after_frame_tx", 64'(tx), 64'd1);

        // 3: back-to-back frames with no idle gap
        bus_write(BASE, 32'h0000_0041);
        bus_write(BASE, 32'h0000_0042);
        check_frame("b2b_41", 8'h41);
        check_frame("b2b_42", 8'h42);
        check("b2b_busy_done", 64'(tx_busy), 64'd0);
        check_status("b2b_status", 32'h0000_0002);

        // 4: overflow, ovf clear, nine frames with the tenth byte dropped
        for (int i = 0; i < 10; i++) begin
            bus_write(BASE, 32'(8'h10 + i));
        end
        check_status("ovf_status", 32'h0000_008D);
        bus_write(BASE + 32'd4, 32'h0000_0008);
        check_status("ovf_cleared", 32'h0000_0085);
        repeat (30) tick();
        check("frame1_stop", 64'(tx), 64'd1);
        tick();
        for (int i = 1; i < 9; i++) begin
            check_frame($sformatf("ovf_frame%0d", i + 1), 8'(8'h10 + i));
        end
        check("ovf_done_busy", 64'(tx_busy), 64'd0);
        check("ovf_done_tx", 64'(tx), 64'd1);
        check_status("ovf_done_status", 32'h0000_0002);

        // 5: reset mid-DATA with bytes queued, reset beats a same-cycle write
        for (int i = 0; i < 4; i++) begin
            bus_write(BASE, 32'(8'hA1 + i));
        end
        repeat (9) tick();
        check("mid_frame_busy", 64'(tx_busy), 64'd1);
        reset    = 1'b1;
        mem_addr = BASE;
        data_in  = 32'h0000_0077;
        memwr    = 1'b1;
        tick();
        reset = 1'b0;
        memwr = 1'b0;
        check("rst_tx", 64'(tx), 64'd1);
        check("rst_busy", 64'(tx_busy), 64'd0);
        check_status("rst_status", 32'h0000_0002);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        check("rst_no_frames", 64'(bad), 64'd0);

        // 6: address decode
        mem_addr = BASE + 32'd8;
        data_in  = 32'h0000_0033;
        memwr    = 1'b1;
        #1;
        check("miss_sel", 64'(sel), 64'd0);
        check("miss_data_out", 64'(data_out), 64'd0);
        tick();
        memwr = 1'b0;
        check_status("miss_no_push", 32'h0000_0002);
        tick();
        check("miss_no_busy", 64'(tx_busy), 64'd0);
        read_word(BASE + 32'd4, 1'b0, v);
        check("status_no_memrd", 64'(v), 64'h0000_0002);
        read_word(BASE, 1'b1, v);
        check("txdata_reads_0", 64'(v), 64'd0);
        check("txdata_sel", 64'(sel), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the CPU data-memory bus, a sibling of the data RAM. It decodes the CPU data port (`mem_addr`, `memwr`, `memrd`, write data), and queues bytes written to its TXDATA register in a small FIFO. It serialises those bytes as 8N1 frames on `tx`. It also returns a status word for CPU reads; the computer top muxes that word with the RAM output using `sel`.

## Interface
Parameters:
- `BASE_ADDR`, default 32'hFFFF_0000. Byte address of TXDATA; STATUS is at BASE_ADDR+4. Must be 8-byte aligned.
- `CLK_DIV`, default 434. Clock cycles per serial bit. Legal range is ≥2.
- `FIFO_DEPTH`, default 8. Power of two, 2..16.

Ports:
- `clk`  in  1  system clock; everything is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_addr`  in  32  CPU data address.
- `memwr`  in  1  CPU write strobe, single cycle per access.
- `memrd`  in  1  CPU read strobe.
- `data_in`  in  32  CPU write data.
- `data_out`  out  32  read data, combinational.
- `sel`  out  1  combinational; 1 when `mem_addr[31:3] == BASE_ADDR[31:3]`.
- `tx`  out  1  serial line, registered, idle high.
- `tx_busy`  out  1  registered; 1 while the FSM is outside IDLE.

## Operation
- Decode:
  - `hit = sel`. Word select is `mem_addr[2]`: 0 = TXDATA, 1 = STATUS. `mem_addr[1:0]` is ignored.
  - The block never writes or reads the RAM; the top gates the RAM strobes with `~sel`.
- TXDATA write (`hit & memwr & ~mem_addr[2]`):
  - If not full, push `data_in[7:0]`; bits 31:8 are ignored.
  - If full, drop the byte and set sticky `ovf`.
  - Fullness is evaluated before any same-cycle pop, so a push to a full FIFO is dropped even if the FSM pops in that cycle.
- STATUS write (`hit & memwr & mem_addr[2]`):
  - Writing 1 to bit 3 clears `ovf`.
  - All other bits are ignored.
- Reads: `data_out` is combinational and independent of `memrd`.
  - `hit` and TXDATA selected: `data_out = 0`.
  - `hit` and STATUS selected: `data_out = {24'b0, count[3:0], ovf, tx_busy, empty, full}`, i.e. bit0 full, bit1 empty, bit2 tx_busy, bit3 ovf, bits7:4 FIFO count. For FIFO_DEPTH=16 a full FIFO reads count as 0, with full=1.
  - No `hit`: `data_out = 0`.
- FIFO: circular buffer with read/write pointers and a count register. Pointers wrap modulo FIFO_DEPTH. A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- TX FSM states: IDLE, START, DATA, STOP. A baud counter `bcnt` runs 0..CLK_DIV-1 and a bit index `bidx` runs 0..7.
  - IDLE: `tx=1`. If FIFO is non-empty, pop into `shreg`, set `bcnt=0`, go to START.
  - START: `tx=0`. When `bcnt==CLK_DIV-1`, go to DATA with `bidx=0`.
  - DATA: `tx=shreg[bidx]`, LSB first. At `bcnt==CLK_DIV-1`, increment `bidx`. After bit 7, go to STOP.
  - STOP: `tx=1`. At `bcnt==CLK_DIV-1`:
    - if FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- `bcnt` resets to 0 on every state or bit transition.

## Timing
- Reset values: `tx=1`, `tx_busy=0`, state IDLE, FIFO empty (pointers and count 0), `ovf=0`, `bcnt=0`, `bidx=0`.
- Reset asserted mid-frame aborts the frame and discards FIFO contents. `tx` is 1 after the reset edge.
- Reset has priority over a same-cycle write.
- Write latency:
  - A write sampled at edge E0 makes count=1 after E0.
  - The FSM pops at E1, so `tx` falls and `tx_busy` rises after E1.
  - Count returns to 0 after E1.
- Frame length is exactly 10×CLK_DIV cycles: start 1, data 8, stop 1, each CLK_DIV cycles.
- Back-to-back frames: the next start bit begins the cycle after the last stop-bit cycle.
- `tx_busy` falls on the edge on which STOP exits to IDLE.
- STATUS reads reflect register state after the most recent edge. A same-cycle write is not visible until the next cycle.

## Test plan
1. Reset, then idle 20 cycles → `tx=1`, `tx_busy=0`, STATUS read = 32'h0000_0002.
2. CLK_DIV=4: write 32'h0000_0155 to TXDATA.
   - `tx` falls one cycle after the write edge.
   - Line carries 0, then 1,0,1,0,1,0,1,0, then 1, each held 4 cycles; 40 cycles total.
   - `tx_busy` drops after the frame.
   - Bits 31:8 are ignored.
3. Write 0x41 then 0x42 on consecutive cycles → two contiguous frames of 80 cycles total, with no idle high gap between the stop bit of 0x41 and the start bit of 0x42.
4. FIFO_DEPTH=8, CLK_DIV=100: write 10 bytes on consecutive cycles.
   - The first byte is popped into the FSM; the next 8 fill the FIFO; the 10th is dropped.
   - STATUS = full=1, ovf=1, count=8 → 32'h0000_008D.
   - Write STATUS with 0x8 → ovf clears.
   - Exactly 9 frames are observed.
5. Assert `reset` mid-DATA of a frame with 3 bytes queued → `tx=1` next cycle, STATUS=0x2, no further frames.
6. Address decode:
   - Write to BASE_ADDR+8 → `sel=0`, no push.
   - Read from BASE_ADDR+4 with `memrd` low → `data_out` still shows STATUS.
   - Read from BASE_ADDR+0 → `data_out = 0`.
